// File: rtl/y86_bus_mem.sv
// Byte-addressed zero-wait-state memory that responds on the y86 core bus, with a boot loader port
// and a fault checker. Define Y86_MEM_STATS_EN to add the rd_count/wr_count counters.
module y86_bus_mem #(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   bus_A,
  input  logic          bus_RE,
  input  logic          bus_WE,
  input  logic [31:0]   bus_out,
  output logic [31:0]   bus_in,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          cpu_rst,
  output logic [1:0]    state,
  output logic          err
`ifdef Y86_MEM_STATS_EN
  ,
  output logic [31:0]   rd_count,
  output logic [31:0]   wr_count
`endif
);

  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StRun   = 2'd1,
    StFault = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   cpu_rst_q;

  logic [7:0] mem [(1 << AW)];

  logic [AW-1:0] a0, a1, a2, a3;
  logic          in_range, run, rd_ok, wr_ok, viol, ld_we;
  logic [31:0]   rd_word;

  // Byte indices wrap at the top of memory through AW-bit arithmetic.
  assign a0 = bus_A[AW-1:0];
  assign a1 = a0 + AW'(1);
  assign a2 = a0 + AW'(2);
  assign a3 = a0 + AW'(3);

  assign in_range = ~|bus_A[31:AW];
  assign run      = (state_q == StRun);
  assign rd_ok    = run & bus_RE & ~bus_WE & in_range;
  assign wr_ok    = run & bus_WE & ~bus_RE & in_range & ~rst;
  assign viol     = run & ((bus_RE & bus_WE) | ((bus_RE | bus_WE) & ~in_range));
  assign ld_we    = (state_q == StLoad) & ld_valid & ~rst;
  assign rd_word  = {mem[a3], mem[a2], mem[a1], mem[a0]};

  // Storage has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end else if (wr_ok) begin
      mem[a0] <= bus_out[7:0];
      mem[a1] <= bus_out[15:8];
      mem[a2] <= bus_out[23:16];
      mem[a3] <= bus_out[31:24];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLoad;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cpu_rst_q <= (state_d != StRun);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StLoad:  if (ld_valid && ld_last) state_d = StRun;
      StRun:   if (viol) state_d = StFault;
      StFault: state_d = StFault;
      default: state_d = StLoad;
    endcase
  end

  always_comb begin
    ld_ready = 1'b0;
    err      = 1'b0;
    bus_in   = '0;
    case (state_q)
      StLoad:  ld_ready = 1'b1;
      StRun:   if (rd_ok) bus_in = rd_word;
      StFault: err = 1'b1;
      default: ;
    endcase
  end

  assign cpu_rst = cpu_rst_q;
  assign state   = state_q;

`ifdef Y86_MEM_STATS_EN
  logic [31:0] rd_count_q, wr_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      if (rd_ok) rd_count_q <= rd_count_q + 32'd1;
      if (wr_ok) wr_count_q <= wr_count_q + 32'd1;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule
